ixu_wb_queue: RTL and testbench
===============================

# ixu_wb_queue

Multi-lane, in-order writeback buffer for the integer execution unit. Accepts one VLIW bundle of up to LANES integer results per cycle and drains them to the register file through WR_PORTS registered write ports, oldest first. Replaces the single-lane combinational writeback with:
- per-lane nop and x0 suppression
- intra-drain same-register squashing
- back-pressure
- a pending-write lookup port for the issue scoreboard

## Interface
Parameters:
- LANES, 4, result lanes per bundle
- WR_PORTS, 2, register-file write ports (1..LANES)
- DEPTH, 8, shared buffer entries (power of 2, ≥ LANES)
- XLEN, 32, data width
- RAW, 5, register address width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  bundle present
- in_ready  out  1  bundle accepted when in_valid && in_ready
- is_nop  in  LANES  per-lane nop flag
- rd  in  LANES*RAW  per-lane destination; lane i at [i*RAW +: RAW]
- data_in  in  LANES*XLEN  per-lane result
- wr_en  out  WR_PORTS  per-port write enable
- rd_out  out  WR_PORTS*RAW  per-port destination
- data_out  out  WR_PORTS*XLEN  per-port data
- pend_rd  in  RAW  scoreboard query register
- pend_hit  out  1  write to pend_rd still outstanding
- pend_data  out  XLEN  youngest pending value for pend_rd (IXU_WB_FWD_EN only)
- wb_empty  out  1  buffer empty and no write on the ports

## Operation
- Circular buffer of DEPTH entries, each {rd, data}, with head, tail and count (width clog2(DEPTH+1)).
- Enqueue:
  - On accept, lanes with is_nop=0 and rd≠0 are written at tail in ascending lane order. Lanes with is_nop=1 or rd=0 are dropped.
  - Tail advances by the number kept, modulo DEPTH.
  - A bundle with zero kept lanes is accepted and changes nothing.
- in_ready = (DEPTH − count) ≥ LANES, from current count only; same-cycle dequeue is not credited.
- Dequeue:
  - Each cycle, n = min(count, WR_PORTS) entries are taken from head.
  - Entry head+k goes to port k. Head advances by n.
  - Ports k ≥ n get wr_en=0, rd_out=0, data_out=0.
- Squash: among the n entries taken in one cycle, if an older entry's rd equals a younger one's, the older port's wr_en=0. Both entries are consumed. The younger value wins.
- Simultaneous enqueue and dequeue are permitted. Next count = count + kept − n.
- pend_hit is 1 if pend_rd≠0 and it matches any valid buffer entry or any port with wr_en=1. pend_hit is always 0 for pend_rd=0.
- wb_empty = (count==0) && (wr_en==0).

## Timing
- rd_out, data_out and wr_en are registered. pend_hit, pend_data, in_ready and wb_empty are combinational from registered state plus pend_rd.
- Latency: a result accepted at edge E is written into the buffer at E and appears on a write port in the cycle following edge E+1, when the queue ahead of it is empty.
- Throughput: sustained min(LANES kept, WR_PORTS) writes per cycle.
- A full buffer deasserts in_ready. Upstream must hold the bundle stable until accepted.
- Wrap: head and tail wrap modulo DEPTH with no bubble. Multi-entry reads and writes may straddle index DEPTH−1 → 0.
- Reset values, forced immediately and asynchronously, also when asserted mid-drain: head=tail=count=0, wr_en=0, rd_out=0, data_out=0. Buffered entries are discarded.
- Outputs during reset: in_ready=1 (since DEPTH ≥ LANES), pend_hit=0, wb_empty=1, pend_data=0.

## Configuration
- IXU_WB_FWD_EN defined:
  - pend_data returns the data of the youngest match for pend_rd.
  - Search order: buffer tail−1 down to head, then ports WR_PORTS−1 down to 0.
  - pend_data=0 when pend_hit=0.
- IXU_WB_FWD_EN undefined: pend_data is tied to 0 and no data-compare muxes are built. pend_hit behaviour is unchanged.

## Test plan
- Reset, then bundle {lane0 rd=3 0xA, lane1 nop, lane2 rd=0 0xB, lane3 rd=7 0xC} → next-but-one cycle: port0 rd=3 0xA, port1 rd=7 0xC. x0 and nop are never written. Next cycle wb_empty=1.
- Bundle {rd=5 0x1, rd=5 0x2, rd=6 0x3, rd=5 0x4} with WR_PORTS=2:
  - Cycle 1: port0 squashed (wr_en=0), port1 rd=5 0x2.
  - Cycle 2: rd=6 0x3 and rd=5 0x4 both written.
  - Final value of r5 = 0x4.
- Four back-to-back full bundles with no stall on the write side → in_ready drops once count > DEPTH−LANES. No accepted entry is lost or reordered; the 16 writes emerge in order, 2 per cycle.
- Fill to force head/tail wrap across index 7→0 during a 2-wide dequeue → port order and data correct across the wrap.
- pend_rd=9 while rd=9 is queued → pend_hit=1; with IXU_WB_FWD_EN, pend_data equals the youngest value. Once the write leaves the ports, pend_hit=0. pend_rd=0 → pend_hit=0.
- Assert rst with 6 entries queued and a write on the ports → wr_en=0 immediately. After release: count=0, wb_empty=1, and no stale writes appear.

Source files
------------

// File: rtl/ixu_wb_queue.sv
// Purpose : in-order multi-lane writeback buffer between the IXU result lanes and the register file.
// Latency : a result accepted at edge E reaches a write port in the cycle after edge E+1 (queue ahead empty).
// Backpr. : in_ready drops when fewer than LANES free entries remain; a held bundle is taken once space frees.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   in_valid/in_ready   bundle handshake (accept = in_valid && in_ready)
//   is_nop, rd, data_in per-lane nop flag, destination, result (lane i at [i*W +: W])
//   wr_en, rd_out,      registered register-file write ports, oldest entry on port 0
//   data_out
//   pend_rd, pend_hit,  scoreboard query: write to pend_rd still queued or on the ports;
//   pend_data           youngest pending value (only with IXU_WB_FWD_EN, otherwise 0)
//   wb_empty            nothing buffered and nothing on the ports
//
// Optional feature macro: IXU_WB_FWD_EN (pending-data forwarding).
module ixu_wb_queue #(
  parameter int LANES    = 4,
  parameter int WR_PORTS = 2,
  parameter int DEPTH    = 8,
  parameter int XLEN     = 32,
  parameter int RAW      = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES-1:0]         is_nop,
  input  logic [LANES*RAW-1:0]     rd,
  input  logic [LANES*XLEN-1:0]    data_in,
  output logic [WR_PORTS-1:0]      wr_en,
  output logic [WR_PORTS*RAW-1:0]  rd_out,
  output logic [WR_PORTS*XLEN-1:0] data_out,
  input  logic [RAW-1:0]           pend_rd,
  output logic                     pend_hit,
  output logic [XLEN-1:0]          pend_data,
  output logic                     wb_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Storage and pointers. Pointer arithmetic wraps naturally since DEPTH is a power of 2.
  logic [RAW-1:0]            r_mem_rd   [DEPTH];
  logic [XLEN-1:0]           r_mem_data [DEPTH];
  logic [PTR_W-1:0]          r_head;
  logic [PTR_W-1:0]          r_tail;
  logic [CNT_W-1:0]          r_count;
  logic [WR_PORTS-1:0]       r_wr_en;
  logic [WR_PORTS*RAW-1:0]   r_rd_out;
  logic [WR_PORTS*XLEN-1:0]  r_data_out;

  // ---------------------------------------------------------------------------
  // Enqueue: compact kept lanes into consecutive slots starting at tail.
  // ---------------------------------------------------------------------------
  logic                      w_accept;
  logic [LANES-1:0]          w_keep;
  logic [PTR_W-1:0]          w_lane_idx [LANES];
  logic [CNT_W-1:0]          w_n_keep;

  assign in_ready = (CNT_W'(DEPTH) - r_count) >= CNT_W'(LANES);
  assign w_accept = in_valid && in_ready;

  // Running count of kept lanes gives each kept lane its slot offset from tail.
  always_comb begin
    w_keep   = '0;
    w_n_keep = '0;
    for (int i = 0; i < LANES; i++) begin
      w_keep[i]     = !is_nop[i] && (rd[i*RAW +: RAW] != '0);
      w_lane_idx[i] = r_tail + w_n_keep[PTR_W-1:0];
      if (w_keep[i]) begin
        w_n_keep = w_n_keep + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Dequeue: take min(count, WR_PORTS) oldest entries, port k gets head+k.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0]          w_n_deq;
  logic [WR_PORTS-1:0]       w_take;
  logic [WR_PORTS-1:0]       w_port_we;
  logic [PTR_W-1:0]          w_port_idx [WR_PORTS];

  assign w_n_deq = (r_count > CNT_W'(WR_PORTS)) ? CNT_W'(WR_PORTS) : r_count;

  // An older entry is squashed when a younger entry taken in the same cycle
  // targets the same register; the younger value is the architectural one.
  always_comb begin
    w_take    = '0;
    w_port_we = '0;
    for (int k = 0; k < WR_PORTS; k++) begin
      w_port_idx[k] = r_head + PTR_W'(k);
      w_take[k]     = CNT_W'(k) < w_n_deq;
    end
    for (int k = 0; k < WR_PORTS; k++) begin
      w_port_we[k] = w_take[k];
      for (int j = k + 1; j < WR_PORTS; j++) begin
        if (w_take[j] && (r_mem_rd[w_port_idx[j]] == r_mem_rd[w_port_idx[k]])) begin
          w_port_we[k] = 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State and registered write ports.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_wr_en    <= '0;
      r_rd_out   <= '0;
      r_data_out <= '0;
    end else begin
      r_head  <= r_head + w_n_deq[PTR_W-1:0];
      r_tail  <= r_tail + (w_accept ? w_n_keep[PTR_W-1:0] : '0);
      r_count <= r_count + (w_accept ? w_n_keep : '0) - w_n_deq;
      for (int k = 0; k < WR_PORTS; k++) begin
        r_wr_en[k]                  <= w_port_we[k];
        r_rd_out[k*RAW +: RAW]      <= w_take[k] ? r_mem_rd[w_port_idx[k]]   : '0;
        r_data_out[k*XLEN +: XLEN]  <= w_take[k] ? r_mem_data[w_port_idx[k]] : '0;
      end
    end
  end

  // Entry payload needs no reset: validity is tracked by head/count alone.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int i = 0; i < LANES; i++) begin
        if (w_keep[i]) begin
          r_mem_rd[w_lane_idx[i]]   <= rd[i*RAW +: RAW];
          r_mem_data[w_lane_idx[i]] <= data_in[i*XLEN +: XLEN];
        end
      end
    end
  end

  assign wr_en    = r_wr_en;
  assign rd_out   = r_rd_out;
  assign data_out = r_data_out;
  assign wb_empty = (r_count == '0) && (r_wr_en == '0);

  // ---------------------------------------------------------------------------
  // Pending-write lookup. Scan ports first, then buffer oldest to youngest, so
  // the last match assigned is the youngest one (buffer beats ports).
  // ---------------------------------------------------------------------------
  logic w_pend_hit;
`ifdef IXU_WB_FWD_EN
  logic [XLEN-1:0] w_pend_data;
`endif

  always_comb begin
    w_pend_hit = 1'b0;
`ifdef IXU_WB_FWD_EN
    w_pend_data = '0;
`endif
    if (pend_rd != '0) begin
      for (int k = 0; k < WR_PORTS; k++) begin
        if (r_wr_en[k] && (r_rd_out[k*RAW +: RAW] == pend_rd)) begin
          w_pend_hit = 1'b1;
`ifdef IXU_WB_FWD_EN
          w_pend_data = r_data_out[k*XLEN +: XLEN];
`endif
        end
      end
      for (int a = 0; a < DEPTH; a++) begin
        if ((CNT_W'(a) < r_count) && (r_mem_rd[r_head + PTR_W'(a)] == pend_rd)) begin
          w_pend_hit = 1'b1;
`ifdef IXU_WB_FWD_EN
          w_pend_data = r_mem_data[r_head + PTR_W'(a)];
`endif
        end
      end
    end
  end

  assign pend_hit = w_pend_hit;
`ifdef IXU_WB_FWD_EN
  assign pend_data = w_pend_data;
`else
  assign pend_data = '0;
`endif

endmodule

// File: tb/tb_ixu_wb_queue.sv
// Purpose : directed, table-driven checks of ixu_wb_queue (default parameters).
// Latency : each vector's expected outputs are those visible while its inputs are presented.
// Backpr. : back-to-back bundles are held until in_ready, mirroring an upstream stage.
module tb_ixu_wb_queue;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    is_nop;
  logic [19:0]   rd;
  logic [127:0]  data_in;
  logic [1:0]    wr_en;
  logic [9:0]    rd_out;
  logic [63:0]   data_out;
  logic [4:0]    pend_rd;
  logic          pend_hit;
  logic [31:0]   pend_data;
  logic          wb_empty;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ixu_wb_queue dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .is_nop(is_nop), .rd(rd), .data_in(data_in),
    .wr_en(wr_en), .rd_out(rd_out), .data_out(data_out),
    .pend_rd(pend_rd), .pend_hit(pend_hit), .pend_data(pend_data),
    .wb_empty(wb_empty)
  );

  typedef struct {
    logic         iv;
    logic [3:0]   nop;
    logic [19:0]  rdv;
    logic [127:0] din;
    logic [4:0]   prd;
    logic [1:0]   we;
    logic [9:0]   rdo;
    logic [63:0]  dout;
    logic         rdy;
    logic         hit;
    logic [31:0]  pd;
    logic         emp;
  } vec_t;

  localparam int NV = 15;
  vec_t tv [NV];
  logic [31:0] rf [32];

  function automatic vec_t mk(logic iv, logic [3:0] nop, logic [19:0] rdv, logic [127:0] din,
                              logic [4:0] prd, logic [1:0] we, logic [9:0] rdo, logic [63:0] dout,
                              logic rdy, logic hit, logic [31:0] pd, logic emp);
    vec_t v;
    v.iv = iv; v.nop = nop; v.rdv = rdv; v.din = din; v.prd = prd;
    v.we = we; v.rdo = rdo; v.dout = dout; v.rdy = rdy; v.hit = hit; v.pd = pd; v.emp = emp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [31:0] v);
`ifdef IXU_WB_FWD_EN
    return v;
`else
    return 32'd0 & v;
`endif
  endfunction

  task automatic idle_inputs();
    in_valid = 1'b0; is_nop = '0; rd = '0; data_in = '0;
  endtask

  // Back-to-back bookkeeping
  logic [4:0]  got_rd   [$];
  logic [31:0] got_data [$];

  initial begin
    int b, active, pairs, cyc;
    logic saw_stall;

    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, active, pairs;
    logic saw_stall, acc;

    for (int r = 0; r < 32; r++) rf[r] = 32'd0;

    // --- directed vectors: {inputs, expected outputs during that cycle} ---
    // Scenario 1: nop and x0 dropped, two kept lanes drained 2-wide.
    tv[0]  = mk(1, 4'b0010, {5'd7,5'd0,5'd4,5'd3}, {32'hC,32'hB,32'h44,32'hA}, 5'd3,
                2'b00, 10'd0, 64'd0, 1, 0, 32'h0, 1);
    tv[1]  = mk(0, 4'b0, 20'd0, 128'd0, 5'd7, 2'b00, 10'd0, 64'd0, 1, 1, fwd(32'hC), 0);
    tv[2]  = mk(0, 4'b0, 20'd0, 128'd0, 5'd3, 2'b11, {5'd7,5'd3}, {32'hC,32'hA}, 1, 1, fwd(32'hA), 0);
    tv[3]  = mk(0, 4'b0, 20'd0, 128'd0, 5'd3, 2'b00, 10'd0, 64'd0, 1, 0, 32'h0, 1);
    // Scenario 2: same-register squash inside one drain.
    tv[4]  = mk(1, 4'b0, {5'd5,5'd6,5'd5,5'd5}, {32'h4,32'h3,32'h2,32'h1}, 5'd0,
                2'b00, 10'd0, 64'd0, 1, 0, 32'h0, 1);
    tv[5]  = mk(0, 4'b0, 20'd0, 128'd0, 5'd5, 2'b00, 10'd0, 64'd0, 1, 1, fwd(32'h4), 0);
    tv[6]  = mk(0, 4'b0, 20'd0, 128'd0, 5'd5, 2'b10, {5'd5,5'd5}, {32'h2,32'h1}, 1, 1, fwd(32'h4), 0);
    tv[7]  = mk(0, 4'b0, 20'd0, 128'd0, 5'd6, 2'b11, {5'd5,5'd6}, {32'h4,32'h3}, 1, 1, fwd(32'h3), 0);
    tv[8]  = mk(0, 4'b0, 20'd0, 128'd0, 5'd6, 2'b00, 10'd0, 64'd0, 1, 0, 32'h0, 1);
    // Wrap: one entry moves head to 7, then a 4-entry bundle straddles 7->0.
    tv[9]  = mk(1, 4'b1110, {5'd1,5'd1,5'd1,5'd20}, {32'h1,32'h1,32'h1,32'h20}, 5'd9,
                2'b00, 10'd0, 64'd0, 1, 0, 32'h0, 1);
    tv[10] = mk(1, 4'b0, {5'd11,5'd9,5'd10,5'd9}, {32'hB0,32'h92,32'hA0,32'h91}, 5'd9,
                2'b00, 10'd0, 64'd0, 1, 0, 32'h0, 0);
    tv[11] = mk(0, 4'b0, 20'd0, 128'd0, 5'd9, 2'b01, {5'd0,5'd20}, {32'h0,32'h20}, 1, 1, fwd(32'h92), 0);
    tv[12] = mk(0, 4'b0, 20'd0, 128'd0, 5'd9, 2'b11, {5'd10,5'd9}, {32'hA0,32'h91}, 1, 1, fwd(32'h92), 0);
    tv[13] = mk(0, 4'b0, 20'd0, 128'd0, 5'd9, 2'b11, {5'd11,5'd9}, {32'hB0,32'h92}, 1, 1, fwd(32'h92), 0);
    tv[14] = mk(0, 4'b0, 20'd0, 128'd0, 5'd9, 2'b00, 10'd0, 64'd0, 1, 0, 32'h0, 1);

    // --- reset ---
    rst = 1'b1; idle_inputs(); pend_rd = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset wr_en", 128'(wr_en), 128'd0);
    chk("reset wb_empty", 128'(wb_empty), 128'd1);
    chk("reset in_ready", 128'(in_ready), 128'd1);
    chk("reset pend_hit", 128'(pend_hit), 128'd0);
    chk("reset pend_data", 128'(pend_data), 128'd0);
    rst = 1'b0;

    // --- table ---
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      in_valid = tv[i].iv; is_nop = tv[i].nop; rd = tv[i].rdv; data_in = tv[i].din;
      pend_rd = tv[i].prd;
      #1;
      chk($sformatf("v%0d wr_en", i),     128'(wr_en),     128'(tv[i].we));
      chk($sformatf("v%0d rd_out", i),    128'(rd_out),    128'(tv[i].rdo));
      chk($sformatf("v%0d data_out", i),  128'(data_out),  128'(tv[i].dout));
      chk($sformatf("v%0d in_ready", i),  128'(in_ready),  128'(tv[i].rdy));
      chk($sformatf("v%0d pend_hit", i),  128'(pend_hit),  128'(tv[i].hit));
      chk($sformatf("v%0d pend_data", i), 128'(pend_data), 128'(tv[i].pd));
      chk($sformatf("v%0d wb_empty", i),  128'(wb_empty),  128'(tv[i].emp));
      for (int p = 0; p < 2; p++)
        if (wr_en[p]) rf[rd_out[p*5 +: 5]] = data_out[p*32 +: 32];
    end
    idle_inputs();
    chk("rf r3", 128'(rf[3]), 128'h A);
    chk("rf r7", 128'(rf[7]), 128'h C);
    chk("rf r5 final", 128'(rf[5]), 128'h4);
    chk("rf r6", 128'(rf[6]), 128'h3);
    chk("rf r9 final", 128'(rf[9]), 128'h92);
    chk("rf r0 untouched", 128'(rf[0]), 128'd0);
    chk("rf r4 nop untouched", 128'(rf[4]), 128'd0);
    chk("rf r1 nop untouched", 128'(rf[1]), 128'd0);

    // --- four back-to-back full bundles, upstream holds until accepted ---
    b = 0; active = 0; pairs = 0; saw_stall = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (b < 4) begin
        in_valid = 1'b1; is_nop = '0;
        for (int l = 0; l < 4; l++) begin
          rd[l*5 +: 5]       = 5'(1 + b*4 + l);
          data_in[l*32 +: 32] = 32'h100 + 32'(b*4 + l);
        end
      end else begin
        idle_inputs();
      end
      #1;
      for (int p = 0; p < 2; p++)
        if (wr_en[p]) begin
          got_rd.push_back(rd_out[p*5 +: 5]);
          got_data.push_back(data_out[p*32 +: 32]);
        end
      if (wr_en != 2'b00) active++;
      if (wr_en == 2'b11) pairs++;
      if (b < 4 && !in_ready) saw_stall = 1'b1;
      acc = (b < 4) && in_ready;
      if (acc) b++;
      if (b == 4 && !acc && wb_empty && got_rd.size() == 16) break;
    end
    idle_inputs();
    chk("b2b all bundles accepted", 128'(b), 128'd4);
    chk("b2b write count", 128'(got_rd.size()), 128'd16);
    chk("b2b in_ready stalled", 128'(saw_stall), 128'd1);
    chk("b2b active cycles", 128'(active), 128'd8);
    chk("b2b 2-wide cycles", 128'(pairs), 128'd8);
    if (got_rd.size() == 16) begin
      for (int n = 0; n < 16; n++) begin
        chk($sformatf("b2b order rd %0d", n), 128'(got_rd[n]), 128'(1 + n));
        chk($sformatf("b2b order data %0d", n), 128'(got_data[n]), 128'(32'h100 + 32'(n)));
      end
    end

    // --- reset mid-drain: 6 queued plus a write on the ports ---
    @(negedge clk);
    in_valid = 1'b1; is_nop = '0;
    rd = {5'd24,5'd23,5'd22,5'd21}; data_in = {32'h24,32'h23,32'h22,32'h21};
    @(negedge clk);
    rd = {5'd28,5'd27,5'd26,5'd25}; data_in = {32'h28,32'h27,32'h26,32'h25};
    #1;
    chk("rstmid b accepted", 128'(in_ready), 128'd1);
    @(negedge clk);
    idle_inputs(); pend_rd = 5'd27;
    #1;
    chk("rstmid pre wr_en", 128'(wr_en), 128'h3);
    chk("rstmid pre rd_out", 128'(rd_out), 128'({5'd22,5'd21}));
    chk("rstmid pre pend_hit", 128'(pend_hit), 128'd1);
    #1 rst = 1'b1;
    #1;
    chk("rstmid wr_en", 128'(wr_en), 128'd0);
    chk("rstmid rd_out", 128'(rd_out), 128'd0);
    chk("rstmid data_out", 128'(data_out), 128'd0);
    chk("rstmid wb_empty", 128'(wb_empty), 128'd1);
    chk("rstmid in_ready", 128'(in_ready), 128'd1);
    chk("rstmid pend_hit", 128'(pend_hit), 128'd0);
    chk("rstmid pend_data", 128'(pend_data), 128'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("post-rst wr_en c%0d", c), 128'(wr_en), 128'd0);
      chk($sformatf("post-rst wb_empty c%0d", c), 128'(wb_empty), 128'd1);
      chk($sformatf("post-rst pend_hit c%0d", c), 128'(pend_hit), 128'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
